video_timing: RTL

Raster timing generator for the display path. It produces the horizontal/vertical sync pulses and the current pixel coordinate that the pixel encoder consumes to build `px_data`. Horizontal and vertical counters advance on a pixel-enable strobe. Optional delay stages align the sync outputs with the encoder's registered pixel output. Default geometry is 800x600@60 (40 MHz pixel rate).

---
 rtl/video_pkg.sv | 27 ++
 rtl/video_timing_if.sv | 37 +++
 rtl/sync_delay.sv | 39 +++
 rtl/video_timing.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared timing constants and types for the raster timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pkg;

    // Coordinate width; both totals must fit, i.e. be <= 2047.
    localparam int COORD_W = 11;

    // Default 800x600@60 geometry (40 MHz pixel rate).
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    // Porch phase, shared by the horizontal and vertical FSMs.
    typedef enum logic [1:0] {
        ACT = 2'd0,
        FP  = 2'd1,
        SYN = 2'd2,
        BP  = 2'd3
    } porch_t;

endpackage

// File: rtl/video_timing_if.sv
// Bundle between the timing generator and the pixel encoder.
// Latency: n/a (wires only).
// Backpressure: none; en is the only flow control and comes from the consumer side.
interface video_timing_if;
    import video_pkg::*;

    logic               en;
    logic               hsync;
    logic               vsync;
    logic [COORD_W-1:0] px_x;
    logic [COORD_W-1:0] px_y;
    logic               active;
    logic               line_start;
    logic               frame_start;
`ifdef VT_FRAME_CNT_EN
    logic [7:0]         frame_cnt;
`endif

    modport master (
        input  en,
        output hsync, vsync, px_x, px_y, active, line_start,
`ifdef VT_FRAME_CNT_EN
        frame_cnt,
`endif
        frame_start
    );

    modport slave (
        output en,
        input  hsync, vsync, px_x, px_y, active, line_start,
`ifdef VT_FRAME_CNT_EN
        frame_cnt,
`endif
        frame_start
    );

endinterface

// File: rtl/sync_delay.sv
// Enable-qualified shift register used to align sync with the encoder pipeline.
// Latency: DEPTH pixel ticks (DEPTH=0 is a straight wire).
// Backpressure: shifts only when en is high; holds otherwise.
module sync_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No stages: the caller's register is the only one in the path.
            logic unused_bypass;
            assign unused_bypass = &{1'b0, clk, rst, en};
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] sr [DEPTH];

            // Shift one stage per pixel tick; every stage resets to the inactive level.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
                end else if (en) begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: position, active, line/frame pulses and delayed syncs (optional VT_FRAME_CNT_EN adds frame_cnt).
// Latency: position/active/pulses 1 tick from counter state; hsync/vsync SYNC_DLY ticks later still.
// Backpressure: everything advances only on en; with en low all state and pulses hold.
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int SYNC_DLY = 1     // 0..4
) (
    input  logic           clk,
    input  logic           rst,
    video_timing_if.master vt
);

    // Every porch length is assumed >= 1 so each FSM state is actually visited.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_FP_START  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYN_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_BP_START  = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_FP_START  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_SYN_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_BP_START  = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] SYNC_IDLE = {~HS_POL, ~VS_POL};

    porch_t             h_state_q, h_state_nxt;
    porch_t             v_state_q, v_state_nxt;
    logic [COORD_W-1:0] px_x_q, x_nxt;
    logic [COORD_W-1:0] px_y_q, y_nxt;
    logic               h_wrap;

    logic               active_q, active_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [1:0]         sync_q, sync_d, sync_dly;

    // State register: counters and both porch FSMs, parked on the last blanking pixel at reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_x_q    <= H_LAST;
            px_y_q    <= V_LAST;
            h_state_q <= BP;
            v_state_q <= BP;
        end else if (vt.en) begin
            px_x_q    <= x_nxt;
            px_y_q    <= y_nxt;
            h_state_q <= h_state_nxt;
            v_state_q <= v_state_nxt;
        end
    end

    // Next-state logic: horizontal steps every tick, vertical steps only on the line wrap.
    always_comb begin
        h_wrap = (px_x_q == H_LAST);
        x_nxt  = h_wrap ? '0 : px_x_q + 1'b1;
        y_nxt  = px_y_q;
        if (h_wrap) y_nxt = (px_y_q == V_LAST) ? '0 : px_y_q + 1'b1;

        h_state_nxt = h_state_q;
        case (h_state_q)
            ACT:     if (x_nxt == H_FP_START)  h_state_nxt = FP;
            FP:      if (x_nxt == H_SYN_START) h_state_nxt = SYN;
            SYN:     if (x_nxt == H_BP_START)  h_state_nxt = BP;
            BP:      if (x_nxt == '0)          h_state_nxt = ACT;
            default:                           h_state_nxt = ACT;
        endcase

        v_state_nxt = v_state_q;
        if (h_wrap) begin
            case (v_state_q)
                ACT:     if (y_nxt == V_FP_START)  v_state_nxt = FP;
                FP:      if (y_nxt == V_SYN_START) v_state_nxt = SYN;
                SYN:     if (y_nxt == V_BP_START)  v_state_nxt = BP;
                BP:      if (y_nxt == '0)          v_state_nxt = ACT;
                default:                           v_state_nxt = ACT;
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs line up with px_x/px_y.
    always_comb begin
        active_d      = (h_state_nxt == ACT) && (v_state_nxt == ACT);
        line_start_d  = (x_nxt == '0);
        frame_start_d = (x_nxt == '0) && (y_nxt == '0);
        sync_d[1]     = (h_state_nxt == SYN) ? HS_POL : ~HS_POL;
        sync_d[0]     = (v_state_nxt == SYN) ? VS_POL : ~VS_POL;
    end

    // Output registers; pulses are held (not cleared) while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_q        <= SYNC_IDLE;
        end else if (vt.en) begin
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            sync_q        <= sync_d;
        end
    end

    // Extra sync stages to match the encoder's registered pixel output.
    sync_delay #(
        .DEPTH   (SYNC_DLY),
        .WIDTH   (2),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (vt.en),
        .din  (sync_q),
        .dout (sync_dly)
    );

`ifdef VT_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Count frames on the same tick that frame_start rises into (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 8'd0;
        end else if (vt.en && frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vt.frame_cnt = frame_cnt_q;
`endif

    assign vt.px_x        = px_x_q;
    assign vt.px_y        = px_y_q;
    assign vt.active      = active_q;
    assign vt.line_start  = line_start_q;
    assign vt.frame_start = frame_start_q;
    assign vt.hsync       = sync_dly[1];
    assign vt.vsync       = sync_dly[0];

endmodule
